// File: rtl/snn_param.sv
// snn_param: two-image conv/quantize/pool/FC feature engine with thresholded L1 distance; SNN_CG_EN enables clock gating.
// Result ~4*POOL_DIM^2+1 cycles after the last sample; no backpressure, input ignored outside IDLE/LOAD.
module snn_param #(
   parameter int IMG_DIM = 6,
   parameter int ACT_TH  = 16,
   parameter int OUT_W   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       img,
   input  logic [7:0]       ker,
   input  logic [7:0]       weight,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data
);
   localparam int CONV_DIM = IMG_DIM - 2;
   localparam int PD       = CONV_DIM / 2;
   localparam int PP       = PD * PD;
   localparam int NPIX     = IMG_DIM * IMG_DIM;
   localparam int TOT      = 2 * NPIX;
   localparam int CW       = $clog2(TOT + 1);
   localparam int IW       = $clog2(TOT);
   localparam int PIW      = (PP > 1) ? $clog2(PP) : 1;
   localparam int PW       = (PD > 1) ? $clog2(PD) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
   state_t state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [7:0]       img_buf [TOT];
   logic [7:0]       kbuf    [9];
   logic [7:0]       wbuf    [PP];
   logic [7:0]       pbuf    [PP];
   logic [7:0]       v0_buf  [PP];
   logic             sel_q, ph_q;
   logic [PW-1:0]    r_q, c_q;
   logic [OUT_W-1:0] dist_q, dist_nx, res_q;

   logic             load_fire, load_last, row_end, blk_end, calc_last;
   logic             k_en, w_en, v0_en, acc_en;
   logic             k_clk, w_clk, v0_clk, acc_clk;
   logic [PIW-1:0]   e_ix;
   logic [IW-1:0]    ix;
   logic [19:0]      acc;
   logic [7:0]       q, pool_val, fq, absdiff;
   logic [31:0]      f_acc;

   assign load_fire = in_valid && (state_q == IDLE || state_q == LOAD);
   assign load_last = load_fire && (cnt_q == CW'(TOT - 1));
   assign row_end   = (c_q == PW'(PD - 1));
   assign blk_end   = row_end && (r_q == PW'(PD - 1));
   assign calc_last = (state_q == CALC) && sel_q && ph_q && blk_end;
   assign e_ix      = PIW'(int'(r_q) * PD + int'(c_q));

   assign k_en   = load_fire && (cnt_q < CW'(9));
   assign w_en   = load_fire && (cnt_q < CW'(PP));
   assign v0_en  = (state_q == CALC) && !sel_q && ph_q;
   assign acc_en = (state_q == LOAD) || (state_q == CALC);

`ifdef SNN_CG_EN
   logic k_en_l, w_en_l, v0_en_l, acc_en_l;
   // Enables are captured while clk is low so the gated clocks cannot glitch.
   always_latch begin
      if (!clk) begin
         k_en_l   = k_en;
         w_en_l   = w_en;
         v0_en_l  = v0_en;
         acc_en_l = acc_en;
      end
   end
   assign k_clk   = clk & k_en_l;
   assign w_clk   = clk & w_en_l;
   assign v0_clk  = clk & v0_en_l;
   assign acc_clk = clk & acc_en_l;
`else
   assign k_clk   = clk;
   assign w_clk   = clk;
   assign v0_clk  = clk;
   assign acc_clk = clk;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      out_data  = '0;
      case (state_q)
         IDLE: if (in_valid) state_d = LOAD;
         LOAD: if (load_last) state_d = CALC;
         CALC: if (calc_last) state_d = OUT;
         OUT: begin
            state_d   = IDLE;
            out_valid = 1'b1;
            out_data  = res_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // One pooled cell per cycle: four 3x3 windows, quantized, max taken.
   always_comb begin
      pool_val = '0;
      acc      = '0;
      q        = '0;
      ix       = '0;
      for (int dy = 0; dy < 2; dy++) begin
         for (int dx = 0; dx < 2; dx++) begin
            acc = '0;
            for (int a = 0; a < 3; a++) begin
               for (int b = 0; b < 3; b++) begin
                  ix  = IW'((sel_q ? NPIX : 0) + (2 * int'(r_q) + dy + a) * IMG_DIM
                            + 2 * int'(c_q) + dx + b);
                  acc = acc + 20'(img_buf[ix]) * 20'(kbuf[4'(a * 3 + b)]);
               end
            end
            q = 8'(acc / 20'd2295);
            if (q > pool_val) pool_val = q;
         end
      end
   end

   always_comb begin
      f_acc = '0;
      for (int k = 0; k < PD; k++) begin
         f_acc = f_acc + 32'(pbuf[PIW'(int'(r_q) * PD + k)]) * 32'(wbuf[PIW'(k * PD + int'(c_q))]);
      end
      fq      = 8'(f_acc / 32'(PD * 255));
      absdiff = (v0_buf[e_ix] > fq) ? (v0_buf[e_ix] - fq) : (fq - v0_buf[e_ix]);
      dist_nx = dist_q + OUT_W'(absdiff);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sel_q <= 1'b0;
         ph_q  <= 1'b0;
         r_q   <= '0;
         c_q   <= '0;
         res_q <= '0;
         for (int i = 0; i < TOT; i++) img_buf[i] <= '0;
      end else begin
         if (load_fire) begin
            img_buf[IW'(cnt_q)] <= img;
            cnt_q <= load_last ? '0 : cnt_q + CW'(1);
         end else if (state_q == IDLE) begin
            cnt_q <= '0;
         end
         // Walk (sel, phase, row, col): image 0 pool, image 0 FC, image 1 pool, image 1 FC.
         if (load_last) begin
            sel_q <= 1'b0;
            ph_q  <= 1'b0;
            r_q   <= '0;
            c_q   <= '0;
         end else if (state_q == CALC) begin
            if (row_end) begin
               c_q <= '0;
               if (blk_end) begin
                  r_q  <= '0;
                  ph_q <= ~ph_q;
                  if (ph_q) sel_q <= 1'b1;
               end else begin
                  r_q <= r_q + PW'(1);
               end
            end else begin
               c_q <= c_q + PW'(1);
            end
         end
         if (calc_last) res_q <= (dist_nx < OUT_W'(ACT_TH)) ? '0 : dist_nx;
      end
   end

   always_ff @(posedge k_clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < 9; i++) kbuf[i] <= '0;
      else if (k_en) kbuf[4'(cnt_q)] <= ker;
   end

   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < PP; i++) wbuf[i] <= '0;
      else if (w_en) wbuf[PIW'(cnt_q)] <= weight;
   end

   always_ff @(posedge v0_clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < PP; i++) v0_buf[i] <= '0;
      else if (v0_en) v0_buf[e_ix] <= fq;
   end

   always_ff @(posedge acc_clk or negedge rst_n) begin
      if (!rst_n) begin
         dist_q <= '0;
         for (int i = 0; i < PP; i++) pbuf[i] <= '0;
      end else if (acc_en) begin
         if (load_last) dist_q <= '0;
         else if (state_q == CALC) begin
            if (!ph_q)     pbuf[e_ix] <= pool_val;
            else if (sel_q) dist_q    <= dist_nx;
         end
      end
   end
endmodule

// File: tb/tb_snn_param.sv
// Randomized and directed bench for snn_param at IMG_DIM=6 and IMG_DIM=8 against a plain-arithmetic reference.
module tb_snn_param;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        iv_a, iv_b, ov_a, ov_b;
   logic [7:0]  img_a, ker_a, w_a, img_b, ker_b, w_b;
   logic [9:0]  od_a;
   logic [11:0] od_b;

   snn_param dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .img(img_a), .ker(ker_a),
      .weight(w_a), .out_valid(ov_a), .out_data(od_a)
   );
   snn_param #(.IMG_DIM(8), .ACT_TH(16), .OUT_W(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .img(img_b), .ker(ker_b),
      .weight(w_b), .out_valid(ov_b), .out_data(od_b)
   );

   int n_chk = 0;
   int n_err = 0;
   int px [128];
   int kk [9];
   int ww [9];

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input int dim, input logic v, input logic [7:0] p, input logic [7:0] k,
                        input logic [7:0] w);
      if (dim == 6) begin
         iv_a = v; img_a = p; ker_a = k; w_a = w;
      end else begin
         iv_b = v; img_b = p; ker_b = k; w_b = w;
      end
   endtask

   function automatic logic get_ov(input int dim);
      return (dim == 6) ? ov_a : ov_b;
   endfunction

   function automatic int get_od(input int dim);
      return (dim == 6) ? int'(od_a) : int'(od_b);
   endfunction

   // Straight from the layer definitions: conv, /2295, 2x2 max, P x W, /(pd*255), L1, threshold.
   function automatic int ref_dist(input int dim);
      int cd, pd, npx, s, m, f, d;
      int conv [64];
      int p    [16];
      int v    [2][16];
      cd = dim - 2; pd = cd / 2; npx = dim * dim; d = 0;
      for (int im = 0; im < 2; im++) begin
         for (int y = 0; y < cd; y++)
            for (int x = 0; x < cd; x++) begin
               s = 0;
               for (int a = 0; a < 3; a++)
                  for (int b = 0; b < 3; b++)
                     s += px[im * npx + (y + a) * dim + x + b] * kk[a * 3 + b];
               conv[y * cd + x] = s / 2295;
            end
         for (int i = 0; i < pd; i++)
            for (int j = 0; j < pd; j++) begin
               m = 0;
               for (int dy = 0; dy < 2; dy++)
                  for (int dx = 0; dx < 2; dx++)
                     if (conv[(2 * i + dy) * cd + 2 * j + dx] > m) m = conv[(2 * i + dy) * cd + 2 * j + dx];
               p[i * pd + j] = m;
            end
         for (int i = 0; i < pd; i++)
            for (int j = 0; j < pd; j++) begin
               f = 0;
               for (int k = 0; k < pd; k++) f += p[i * pd + k] * ww[k * pd + j];
               v[im][i * pd + j] = f / (pd * 255);
            end
      end
      for (int e = 0; e < pd * pd; e++)
         d += (v[0][e] > v[1][e]) ? v[0][e] - v[1][e] : v[1][e] - v[0][e];
      return (d < 16) ? 0 : d;
   endfunction

   task automatic fill_const(input int dim, input int a, input int b, input int kv, input int wv);
      for (int i = 0; i < dim * dim; i++) begin
         px[i] = a;
         px[dim * dim + i] = b;
      end
      for (int i = 0; i < 9; i++) begin
         kk[i] = kv;
         ww[i] = wv;
      end
   endtask

   task automatic fill_rand(input int dim, input bit same);
      for (int i = 0; i < dim * dim; i++) begin
         px[i] = $urandom_range(255);
         px[dim * dim + i] = same ? px[i] : $urandom_range(255);
      end
      for (int i = 0; i < 9; i++) begin
         kk[i] = $urandom_range(255);
         ww[i] = $urandom_range(255);
      end
   endtask

   // Caller is #1 after a rising edge; ends #1 after the edge where out_valid has dropped.
   task automatic run_pat(input int dim, input int exp, input string tag);
      int  pp, bound, cyc, got;
      bit  seen, z_ok;
      pp = (dim / 2 - 1) * (dim / 2 - 1);
      bound = dim * dim + 20;
      for (int i = 0; i < 2 * dim * dim; i++) begin
         drive(dim, 1'b1, 8'(px[i]), (i < 9) ? 8'(kk[i]) : 8'($urandom),
               (i < pp) ? 8'(ww[i]) : 8'($urandom));
         @(posedge clk); #1;
      end
      drive(dim, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      cyc = 0; seen = 0; z_ok = 1; got = -1;
      while (cyc <= bound) begin
         if (get_ov(dim)) begin
            seen = 1;
            got  = get_od(dim);
            break;
         end
         if (get_od(dim) != 0) z_ok = 0;
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_valid_in_time"}, seen, 1);
      chk({tag, "_data"}, got, exp);
      chk({tag, "_idle_zero"}, z_ok, 1);
      if (seen) begin
         @(posedge clk); #1;
         chk({tag, "_pulse_width"}, get_ov(dim), 0);
         chk({tag, "_data_cleared"}, get_od(dim), 0);
      end
   endtask

   initial begin
      int hits;
      rst_n = 1'b0;
      drive(6, 1'b0, 8'd0, 8'd0, 8'd0);
      drive(8, 1'b0, 8'd0, 8'd0, 8'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ov_a", ov_a, 0);
      chk("rst_od_a", od_a, 0);
      chk("rst_ov_b", ov_b, 0);
      chk("rst_od_b", od_b, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      fill_const(6, 0, 0, 1, 1);
      run_pat(6, 0, "zero");
      fill_const(6, 255, 0, 255, 255);
      run_pat(6, 1020, "max");
      fill_rand(6, 1);
      run_pat(6, 0, "same_img");

      // Image 1 rows 0-1 at x, weights pick column 0: D = floor(2x/3).
      for (int t = 0; t < 2; t++) begin
         fill_const(6, 0, 0, 255, 0);
         ww[0] = 255; ww[2] = 255;
         for (int i = 0; i < 12; i++) px[36 + i] = (t == 0) ? 23 : 24;
         run_pat(6, (t == 0) ? 0 : 16, (t == 0) ? "d15" : "d16");
      end

      fill_const(6, 255, 0, 255, 255);
      run_pat(6, 1020, "b2b_first");
      fill_const(6, 0, 0, 1, 1);
      run_pat(6, 0, "b2b_second");

      fill_rand(6, 0);
      for (int i = 0; i < 30; i++) begin
         drive(6, 1'b1, 8'(px[i]), 8'(kk[i % 9]), 8'(ww[i % 4]));
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      drive(6, 1'b0, 8'd0, 8'd0, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 100; i++) begin
         if (ov_a) hits++;
         @(posedge clk); #1;
      end
      chk("abort_no_valid", hits, 0);
      fill_rand(6, 0);
      run_pat(6, ref_dist(6), "post_reset");

      fill_const(8, 255, 0, 255, 255);
      run_pat(8, 2295, "dim8_max");

      for (int t = 0; t < 8; t++) begin
         fill_rand(6, (t % 4) == 3);
         run_pat(6, ref_dist(6), "rand6");
      end
      for (int t = 0; t < 4; t++) begin
         fill_rand(8, 0);
         run_pat(8, ref_dist(8), "rand8");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/snn_param.md
# snn_param

Parametrised spiking-network feature-distance engine, the next generation of the lab's fixed 6x6 SNN datapath. It streams in two square images, one 3x3 kernel and one square weight matrix. For each image it runs convolution, quantization, max-pooling, a fully-connected layer and a second quantization, then outputs the thresholded L1 distance between the two feature vectors. Image size and activation threshold are parameters, and optional clock gating is a compile-time feature. It sits at the top of the SNN lab hierarchy and is driven directly by the pattern bench.

## Interface
- IMG_DIM, 6: image side length; even, >= 4. Derived: CONV_DIM = IMG_DIM-2, POOL_DIM = CONV_DIM/2.
- ACT_TH, 16: activation threshold; distances below it output 0.
- OUT_W, 10: out_data width; must satisfy 2^OUT_W > POOL_DIM^2*255.
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  high for exactly 2*IMG_DIM^2 consecutive cycles per pattern.
- img  input  8  unsigned pixel, raster order; image 0, then image 1.
- ker  input  8  unsigned kernel tap, row-major; valid in input cycles 0..8 only.
- weight  input  8  unsigned FC weight, row-major POOL_DIM x POOL_DIM; valid in input cycles 0..POOL_DIM^2-1 only.
- out_valid  output  1  one-cycle result strobe.
- out_data  output  OUT_W  result; 0 whenever out_valid is low.

## Operation
- FSM states:
  - IDLE -> LOAD on in_valid.
  - LOAD -> CALC after the 2*IMG_DIM^2-th sample.
  - CALC -> OUT when the distance is ready.
  - OUT -> IDLE after one cycle.
- Per image k, with all stages unsigned and all divisions floor:
  - Conv: valid 3x3 correlation, stride 1, giving CONV_DIM^2 sums (up to 20 bits).
  - Quantize: conv sum / 2295, result 0..255.
  - Max-pool: 2x2, stride 2, giving a POOL_DIM x POOL_DIM matrix P.
  - FC: F = P x W (matrix product); each element is a sum of POOL_DIM products.
  - Quantize: each F element / (POOL_DIM*255), result 0..255. Flatten row-major to vector Vk.
- Distance: D = sum of |V0[i]-V1[i]| over POOL_DIM^2 elements. out_data = (D < ACT_TH) ? 0 : D.
- Convolution of image 0 may overlap the loading of image 1. Internal scheduling is free within the latency bound.
- in_valid in CALC or OUT: input ignored; the bench guarantees this does not occur.
- All buffers are re-initialised per pattern. No state carries across patterns.

## Timing
- Reset values: out_valid=0, out_data=0, FSM=IDLE, all buffers cleared.
- Reset mid-LOAD or mid-CALC: immediate return to IDLE. No out_valid is produced for the aborted pattern.
- Latency: out_valid rises within IMG_DIM^2+20 cycles after the cycle in_valid falls.
- out_valid is high for exactly 1 cycle per pattern.
- The next pattern's in_valid may rise at earliest 1 cycle after out_valid falls. The block must accept it without idle cycles in between.

## Configuration
- SNN_CG_EN defined:
  - Kernel, weight and image-0 feature registers are clocked through a latch-based clock gate enabled only while they load.
  - The convolution/FC accumulator bank is gated off in IDLE and OUT.
  - A gated register is never written outside its enable window.
- SNN_CG_EN undefined: all registers use clk directly with enable muxes.
- out_valid/out_data sequences must be cycle-identical in both builds.

## Test plan
- Default params, both images all 0, ker=1s, weight=1s -> out_data=0, out_valid one cycle within latency bound.
- Default params, image 0 all 255, image 1 all 0, ker all 255, weight all 255 -> conv 255, pool 255, V0=255s, V1=0s, out_data=1020.
- Default params, images identical random, any ker/weight -> out_data=0. Then a pattern with D=15 -> 0, and one with D=16 -> 16.
- Two back-to-back patterns (second in_valid 1 cycle after out_valid falls): 1020, then 0. Also assert rst_n low mid-LOAD: no out_valid, next full pattern correct.
- IMG_DIM=8, OUT_W=12, image 0 all 255, image 1 all 0, ker/weight all 255 -> out_data=2295 (9*255).
- Run the full suite with and without SNN_CG_EN -> identical output traces. In the gated build, kernel and weight registers show no clock edges during CALC.
